// File: rtl/fp_pkg.sv
// Shared single-precision constants, field positions and FSM types for the
// floating-point arithmetic unit.
package fp_pkg;

   localparam int EXP_W     = 8;
   localparam int MAN_W     = 23;
   localparam int BIAS      = 127;
   localparam int EXT_EXP_W = EXP_W + 2;

   localparam int SIGN_BIT  = 31;
   localparam int EXP_MSB   = 30;
   localparam int EXP_LSB   = 23;
   localparam int MAN_MSB   = 22;
   localparam int MAN_LSB   = 0;

   localparam logic [31:0]      FP_ZERO    = 32'h0000_0000;
   localparam logic [31:0]      FP_QNAN    = 32'h7FC0_0000;
   localparam logic [EXP_W-1:0] FP_INF_EXP = 8'hFF;

   localparam logic signed [EXT_EXP_W-1:0] EXP_MAX = 10'sd254;
   localparam logic signed [EXT_EXP_W-1:0] EXP_MIN = 10'sd1;

   typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_t;

   // Operand class decided at capture and carried to the pack stage.
   typedef enum logic [1:0] {SP_NONE, SP_ZERO, SP_INF, SP_NAN} special_t;

endpackage

// File: rtl/fp_mant_divider.sv
// Restoring mantissa divider: one quotient bit per cycle, 25 bits total,
// q = floor(ma/mb * 2^24). The first bit is resolved on the start edge.
module fp_mant_divider
   import fp_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [MAN_W:0]   ma,
   input  logic [MAN_W:0]   mb,
   output logic [MAN_W+1:0] q,
   output logic             q_valid
);

   localparam int         RW   = MAN_W + 3;
   localparam logic [4:0] LAST = 5'(MAN_W + 1);

   logic [RW-1:0]    r_rem;
   logic [MAN_W:0]   r_mb;
   logic [MAN_W+1:0] r_q;
   logic [4:0]       r_cnt;
   logic             r_run;
   logic             r_q_valid;

   logic [RW-1:0]    w_rem_cur;
   logic [RW-1:0]    w_div_cur;
   logic [RW-1:0]    w_rem_nxt;
   logic             w_ge;

   always_comb begin
      w_rem_cur = start ? RW'(ma) : r_rem;
      w_div_cur = start ? RW'(mb) : RW'(r_mb);
      w_ge      = (w_rem_cur >= w_div_cur);
      w_rem_nxt = w_ge ? ((w_rem_cur - w_div_cur) << 1) : (w_rem_cur << 1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_run     <= 1'b0;
         r_cnt     <= '0;
         r_q_valid <= 1'b0;
      end else begin
         r_q_valid <= 1'b0;
         if (start) begin
            r_run <= 1'b1;
            r_cnt <= 5'd1;
         end else if (r_run) begin
            r_cnt <= r_cnt + 5'd1;
            if (r_cnt == LAST) begin
               r_run     <= 1'b0;
               r_q_valid <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (start) begin
         r_mb <= mb;
      end
      if (start || r_run) begin
         r_rem <= w_rem_nxt;
         r_q   <= start ? (MAN_W+2)'(w_ge) : {r_q[MAN_W:0], w_ge};
      end
   end

   assign q       = r_q;
   assign q_valid = r_q_valid;

endmodule

// File: rtl/fp_divider.sv
// Sequential IEEE-754 single-precision divider (out = in1 / in2), fixed
// 27-cycle latency, truncating, denormals flushed to zero.
module fp_divider
   import fp_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [31:0] in1,
   input  logic [31:0] in2,
   output logic [31:0] out,
   output logic        overflow,
   output logic        div_by_zero,
   output logic        busy,
   output logic        done
);

   state_t                        r_state;
   state_t                        w_next;
   logic                          w_capture;
   logic                          w_norm_en;
   logic                          w_finish;

   logic                          w_q_valid;
   logic [MAN_W+1:0]              w_q;
   logic                          w_a_zero;
   logic                          w_b_zero;
   special_t                      w_special;
   logic signed [EXT_EXP_W-1:0]   w_exp_p0;

   special_t                      r_special;
   logic                          r_sign;
   logic signed [EXT_EXP_W-1:0]   r_exp_p0;
   logic signed [EXT_EXP_W-1:0]   r_exp_p1;
   logic [MAN_W-1:0]              r_man_p1;

   logic [31:0]                   r_out;
   logic                          r_overflow;
   logic                          r_div_by_zero;
   logic                          r_busy;
   logic                          r_done;

   fp_mant_divider u_mant (
      .clk     (clk),
      .reset   (reset),
      .start   (w_capture),
      .ma      ({1'b1, in1[MAN_MSB:MAN_LSB]}),
      .mb      ({1'b1, in2[MAN_MSB:MAN_LSB]}),
      .q       (w_q),
      .q_valid (w_q_valid)
   );

   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (enable) w_next = DIV;
         DIV:     if (w_q_valid) w_next = NORM;
         NORM:    w_next = DONE;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      w_capture = (r_state == IDLE) && enable;
      w_norm_en = (r_state == NORM);
      w_finish  = (r_state == DONE);
   end

   always_comb begin
      w_a_zero  = (in1[EXP_MSB:EXP_LSB] == '0);
      w_b_zero  = (in2[EXP_MSB:EXP_LSB] == '0);
      w_exp_p0  = EXT_EXP_W'(in1[EXP_MSB:EXP_LSB]) - EXT_EXP_W'(in2[EXP_MSB:EXP_LSB])
                  + EXT_EXP_W'(BIAS);
      w_special = SP_NONE;
      if (w_b_zero)      w_special = w_a_zero ? SP_NAN : SP_INF;
      else if (w_a_zero) w_special = SP_ZERO;
   end

   // Capture stage: sign, biased exponent difference and operand class.
   always_ff @(posedge clk) begin
      if (w_capture) begin
         r_sign    <= in1[SIGN_BIT] ^ in2[SIGN_BIT];
         r_exp_p0  <= w_exp_p0;
         r_special <= w_special;
      end
   end

   // Normalise stage: quotient lies in [2^23, 2^25), so at most one shift.
   always_ff @(posedge clk) begin
      if (w_norm_en) begin
         if (w_q[MAN_W+1]) begin
            r_man_p1 <= w_q[MAN_W:1];
            r_exp_p1 <= r_exp_p0;
         end else begin
            r_man_p1 <= w_q[MAN_W-1:0];
            r_exp_p1 <= r_exp_p0 - 10'sd1;
         end
      end
   end

   // Pack stage: result and flags update together with the done pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_out         <= FP_ZERO;
         r_overflow    <= 1'b0;
         r_div_by_zero <= 1'b0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_capture) r_busy <= 1'b1;
         if (w_finish) begin
            r_busy <= 1'b0;
            r_done <= 1'b1;
            case (r_special)
               SP_ZERO: begin
                  r_out         <= FP_ZERO;
                  r_overflow    <= 1'b0;
                  r_div_by_zero <= 1'b0;
               end
               SP_INF: begin
                  r_out         <= {r_sign, FP_INF_EXP, {MAN_W{1'b0}}};
                  r_overflow    <= 1'b0;
                  r_div_by_zero <= 1'b1;
               end
               SP_NAN: begin
                  r_out         <= FP_QNAN;
                  r_overflow    <= 1'b0;
                  r_div_by_zero <= 1'b1;
               end
               default: begin
                  r_out         <= {r_sign, r_exp_p1[EXP_W-1:0], r_man_p1};
                  r_overflow    <= (r_exp_p1 > EXP_MAX) || (r_exp_p1 < EXP_MIN);
                  r_div_by_zero <= 1'b0;
               end
            endcase
         end
      end
   end

   assign out         = r_out;
   assign overflow    = r_overflow;
   assign div_by_zero = r_div_by_zero;
   assign busy        = r_busy;
   assign done        = r_done;

endmodule
